// File: rtl/ball_pkg.sv
// Shared screen geometry, FSM encoding and signed position type for the ball logic.
package ball_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    SCORED     = 2'd2,
    OVER       = 2'd3
  } state_t;

  // 11-bit signed so that moves past either screen edge stay visible before truncation
  typedef logic signed [10:0] pos_t;

  // Upper-left coordinate that centres a ball of side bw along an axis of length extent
  function automatic pos_t centre(input pos_t extent, input logic [5:0] bw);
    pos_t diff;
    diff = extent - pos_t'({5'b0, bw});
    return diff >>> 1;
  endfunction

endpackage

// File: rtl/ball_deflect.sv
// Paddle deflection: picks the new vertical speed from where the ball centre meets the paddle.
module ball_deflect
  import ball_pkg::*;
(
  input  logic [8:0]        ball_y,
  input  logic [5:0]        ball_width,
  input  logic [8:0]        pad_y,
  input  logic [8:0]        length,
  output logic signed [2:0] vy
);

  pos_t off, q, q2, q3;

  // Split the paddle into four bands; the outer bands deflect steeply, the inner ones gently
  always_comb begin
    off = pos_t'({2'b0, ball_y}) + (pos_t'({5'b0, ball_width}) >>> 1) - pos_t'({2'b0, pad_y});
    q   = pos_t'({2'b0, length}) >>> 2;
    q2  = q + q;
    q3  = q2 + q;
    if (off < q)       vy = -3'sd2;
    else if (off < q2) vy = -3'sd1;
    else if (off < q3) vy = 3'sd1;
    else               vy = 3'sd2;
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position, wall/paddle bounces, scoring and serve sequencing for a two-player paddle game.
//
//   state      | meaning
//   SERVE_WAIT | ball shown at centre, waiting for a serve pulse
//   PLAY       | ball advances on each tick, bounces, or a point is scored
//   SCORED     | ball frozen while the hold timer runs down
//   OVER       | a player reached the winning score; only reset leaves
module ball_motion
  import ball_pkg::*;
#(
  parameter int DX         = 4,
  parameter int HOLD_TICKS = 60,
  parameter int WIN_SCORE  = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       serve,
  input  logic [5:0] wall_width,
  input  logic [5:0] ball_width,
  input  logic [5:0] width,
  input  logic [8:0] length,
  input  logic [8:0] lpad_y,
  input  logic [8:0] rpad_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_direction,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int                HOLD_W    = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [3:0]        WIN_S     = 4'(WIN_SCORE);
  localparam pos_t              DX_P      = pos_t'(DX);
  localparam pos_t              SW_P      = pos_t'(SCREEN_W);
  localparam pos_t              SH_P      = pos_t'(SCREEN_H);
  localparam pos_t              ZERO      = '0;

  state_t            state_q, state_d;
  pos_t              x_q, x_d, y_q, y_d;
  logic signed [2:0] vy_q, vy_d, vy_neg, vy_abs, vy_l, vy_r;
  logic              dir_q, dir_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  pos_t              ww, bw, pw, len, lp, rp, cx, cy, r_limit, vy_mag, nx, ny;
  logic              l_overlap, r_overlap, l_hit, r_hit, point_l, point_r, hold_done, win;

  ball_deflect u_deflect_l (
    .ball_y    (y_q[8:0]),
    .ball_width(ball_width),
    .pad_y     (lpad_y),
    .length    (length),
    .vy        (vy_l)
  );

  ball_deflect u_deflect_r (
    .ball_y    (y_q[8:0]),
    .ball_width(ball_width),
    .pad_y     (rpad_y),
    .length    (length),
    .vy        (vy_r)
  );

  // Widen every geometry input to the signed position type and derive shared limits
  always_comb begin
    ww        = pos_t'({5'b0, wall_width});
    bw        = pos_t'({5'b0, ball_width});
    pw        = pos_t'({5'b0, width});
    len       = pos_t'({2'b0, length});
    lp        = pos_t'({2'b0, lpad_y});
    rp        = pos_t'({2'b0, rpad_y});
    cx        = centre(SW_P, ball_width);
    cy        = centre(SH_P, ball_width);
    r_limit   = SW_P - pw - bw;
    vy_neg    = -vy_q;
    vy_abs    = vy_q[2] ? vy_neg : vy_q;
    vy_mag    = pos_t'({8'b0, vy_abs});
    l_overlap = (y_q + bw > lp) && (y_q < lp + len);
    r_overlap = (y_q + bw > rp) && (y_q < rp + len);
    win       = (score_l_q == WIN_S) || (score_r_q == WIN_S);
  end

  // Per-tick motion, bounce and scoring; x and y are resolved independently
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    dir_d     = dir_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;
    nx        = '0;
    ny        = '0;
    l_hit     = 1'b0;
    r_hit     = 1'b0;
    point_l   = 1'b0;
    point_r   = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      SERVE_WAIT: begin
        if (serve) begin
          x_d  = cx;
          y_d  = cy;
          vy_d = '0;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dir_q) begin
            nx = x_q - DX_P;
            if (nx < pw && l_overlap) begin
              x_d   = pw;
              dir_d = 1'b0;
              l_hit = 1'b1;
            end else if (nx < ZERO) begin
              x_d     = ZERO;
              dir_d   = 1'b1;
              point_r = 1'b1;
            end else begin
              x_d = nx;
            end
          end else begin
            nx = x_q + DX_P;
            if (nx > r_limit && r_overlap) begin
              x_d   = r_limit;
              dir_d = 1'b1;
              r_hit = 1'b1;
            end else if (nx + bw > SW_P) begin
              x_d     = SW_P - bw;
              dir_d   = 1'b0;
              point_l = 1'b1;
            end else begin
              x_d = nx;
            end
          end
          if (vy_q < 0) begin
            ny = y_q - vy_mag;
            if (ny < ww) begin
              y_d  = ww;
              vy_d = vy_neg;
            end else begin
              y_d = ny;
            end
          end else if (vy_q > 0) begin
            ny = y_q + vy_mag;
            if (ny + bw > SH_P - ww) begin
              y_d  = SH_P - ww - bw;
              vy_d = vy_neg;
            end else begin
              y_d = ny;
            end
          end
          // A paddle return sets a fresh vertical speed regardless of any wall bounce
          if (l_hit) vy_d = vy_l;
          if (r_hit) vy_d = vy_r;
          if (point_l && score_l_q != WIN_S) score_l_d = score_l_q + 4'd1;
          if (point_r && score_r_q != WIN_S) score_r_d = score_r_q + 4'd1;
          if (point_l || point_r) hold_d = HOLD_LOAD;
        end
      end
      SCORED: begin
        if (tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_done = 1'b1;
            hold_d    = '0;
            x_d       = cx;
            y_d       = cy;
            vy_d      = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SERVE_WAIT;
    else          state_q <= state_d;
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE_WAIT: if (serve) state_d = PLAY;
      PLAY:       if (point_l || point_r) state_d = SCORED;
      SCORED:     if (hold_done) state_d = win ? OVER : SERVE_WAIT;
      default:    state_d = state_q;
    endcase
  end

  // Ball, score and hold-timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      vy_q      <= '0;
      dir_q     <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      hold_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      dir_q     <= dir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hold_q    <= hold_d;
    end
  end

  // Outputs; while waiting for a serve the ball tracks the centre for the current ball size
  always_comb begin
    ball_x = x_q[9:0];
    ball_y = y_q[8:0];
    if (state_q == SERVE_WAIT) begin
      ball_x = cx[9:0];
      ball_y = cy[8:0];
    end
    ball_direction = dir_q;
    score_l        = score_l_q;
    score_r        = score_r_q;
    game_over      = win;
  end

endmodule
